// File: rtl/weigh_ctrl_if.sv
// Signal bundle between the weigh sequencer, the HX711 reader and the host logic.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface weigh_ctrl_if;
  logic        meas_req;
  logic        tare_req;
  logic        pwr_down;
  logic        rd_start;
  logic [1:0]  rd_gain;
  logic        rd_pwrdn;
  logic        rd_done;
  logic [23:0] rd_data;
  logic [23:0] weight;
  logic        weight_valid;
  logic        tare_done;
  logic        busy;
  logic        err_timeout;

  modport slave (
    input  meas_req, tare_req, pwr_down, rd_done, rd_data,
    output rd_start, rd_gain, rd_pwrdn, weight, weight_valid, tare_done, busy, err_timeout
  );

  modport master (
    output meas_req, tare_req, pwr_down, rd_done, rd_data,
    input  rd_start, rd_gain, rd_pwrdn, weight, weight_valid, tare_done, busy, err_timeout
  );
endinterface

// File: rtl/weigh_ctrl.sv
// HX711 measurement sequencer: wake/settle, first-sample discard, 2^AVG_LOG2 averaging,
// tare offset and saturated signed weight output.
module weigh_ctrl #(
  parameter int         AVG_LOG2    = 3,
  parameter int         SETTLE_CYC  = 20_000_000,
  parameter int         TIMEOUT_CYC = 10_000_000,
  parameter logic [1:0] GAIN_SEL    = 2'd0
) (
  input  logic         clk_50,
  input  logic         rst,
  weigh_ctrl_if.slave  bus
);
  localparam int DATA_W = 24;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int TMR_W  = 32;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRDN, S_WAKE, S_IDLE, S_START, S_WAIT, S_ACCUM, S_CALC
  } state_e;

  state_e                    state_q, state_d;
  logic [TMR_W-1:0]          tmr_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      discard_q;
  logic                      tare_mode_q;
  logic                      rd_start_q;
  logic                      rd_pwrdn_q;
  logic                      busy_q;
  logic                      weight_valid_q;
  logic                      tare_done_q;
  logic                      err_q;
  logic signed [DATA_W-1:0]  sample_q;
  logic signed [DATA_W-1:0]  weight_q;
  logic signed [DATA_W-1:0]  offset_q;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [DATA_W-1:0]  avg;
  logic signed [DATA_W-1:0]  meas_w;

  // Arithmetic shift floors toward -inf; the mean of 24-bit samples always fits 24 bits.
  function automatic logic signed [DATA_W-1:0] avg_of(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> AVG_LOG2;
    return sh[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_diff(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = (DATA_W+1)'(a) - (DATA_W+1)'(b);
    if (d[DATA_W] != d[DATA_W-1]) begin
      return d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return d[DATA_W-1:0];
  endfunction

  always_comb begin
    avg    = avg_of(sum_q);
    meas_w = sat_diff(avg, offset_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PWRDN: if (!bus.pwr_down) state_d = S_WAKE;
      S_WAKE:  if (tmr_q == SETTLE_LAST) state_d = S_IDLE;
      S_IDLE: begin
        if (bus.pwr_down)                         state_d = S_PWRDN;
        else if (bus.tare_req || bus.meas_req)    state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.rd_done)             state_d = S_ACCUM;
        else if (tmr_q >= TMO_LAST)  state_d = S_IDLE;
      end
      S_ACCUM: state_d = (!discard_q && cnt_q == CNT_LAST) ? S_CALC : S_START;
      S_CALC:  state_d = S_IDLE;
      default: state_d = S_PWRDN;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q        <= S_PWRDN;
      tmr_q          <= '0;
      cnt_q          <= '0;
      discard_q      <= 1'b0;
      tare_mode_q    <= 1'b0;
      rd_start_q     <= 1'b0;
      rd_pwrdn_q     <= 1'b1;
      busy_q         <= 1'b0;
      weight_valid_q <= 1'b0;
      tare_done_q    <= 1'b0;
      err_q          <= 1'b0;
      weight_q       <= '0;
      offset_q       <= '0;
    end else begin
      // Status outputs are registered from the next state so they line up with state_q.
      state_q        <= state_d;
      rd_pwrdn_q     <= (state_d == S_PWRDN);
      busy_q         <= !(state_d inside {S_IDLE, S_PWRDN});
      rd_start_q     <= (state_d == S_START);
      weight_valid_q <= 1'b0;
      tare_done_q    <= 1'b0;
      unique case (state_q)
        S_PWRDN: tmr_q <= '0;
        S_WAKE: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (state_d == S_IDLE) discard_q <= 1'b1;
        end
        S_IDLE: begin
          if (state_d == S_START) begin
            err_q       <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            tare_mode_q <= bus.tare_req;
          end
        end
        S_START: tmr_q <= '0;
        S_WAIT: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (bus.rd_done)              sample_q <= $signed(bus.rd_data);
          else if (state_d == S_IDLE)   err_q    <= 1'b1;
        end
        S_ACCUM: begin
          if (discard_q) begin
            discard_q <= 1'b0;
          end else begin
            sum_q <= sum_q + SUM_W'(sample_q);
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CALC: begin
          if (tare_mode_q) begin
            offset_q    <= avg;
            tare_done_q <= 1'b1;
          end else begin
            weight_q       <= meas_w;
            weight_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_start     = rd_start_q;
  assign bus.rd_gain      = GAIN_SEL;
  assign bus.rd_pwrdn     = rd_pwrdn_q;
  assign bus.weight       = weight_q;
  assign bus.weight_valid = weight_valid_q;
  assign bus.tare_done    = tare_done_q;
  assign bus.busy         = busy_q;
  assign bus.err_timeout  = err_q;
endmodule
